// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one 1-bit full adder is stepped LSB-first over WIDTH cycles,
// with the carry held in a flop between slices and a start/busy/done handshake.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic             carry_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] shifted_s;

    full_adder u_fa (
        .a    (opa_r[0]),
        .b    (opb_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // The new sum bit enters at the MSB so that after WIDTH slices bit 0 sits at the LSB.
    assign shifted_s = {fa_sum_s, acc_r[WIDTH-1:1]};
    assign last_s    = (cnt_r == CW'(WIDTH - 1));

    // Next-state decode; DONE accepts a new start exactly like IDLE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    next_state_s = RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == RUN);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Operand capture, per-slice shifting, and result load on the final slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
        end else if (accept_s) begin
            opa_r   <= a;
            opb_r   <= b;
            carry_r <= cin;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
            opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
            carry_r <= fa_cout_s;
            acc_r   <= shifted_s;
            cnt_r   <= cnt_r + CW'(1);
            if (last_s) begin
                sum_r  <= shifted_s;
                cout_r <= fa_cout_s;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
        end else begin
            opa_r   <= opa_r;
            opb_r   <= opb_r;
            carry_r <= carry_r;
            acc_r   <= acc_r;
            cnt_r   <= cnt_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random 8-bit operations
// against a plain-arithmetic model, plus an exhaustive sweep at WIDTH=4.

module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int n_chk;
    int n_pass;
    logic [8:0] prev8;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at the negedge after the accepting edge; returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input logic [8:0] hold, input int inj,
                             input logic keep, inout int edges);
        while (!done8 && edges < 40) begin
            chk({tag, "_busy_run"}, 64'(busy8), 64'd1);
            chk({tag, "_sum_hold"}, 64'({cout8, sum8}), 64'(hold));
            if (edges == inj) begin
                start8 = 1'b1;
                a8 = 8'hAA;
                b8 = 8'h55;
            end else begin
                start8 = keep;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            cin8 = 1'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input int inj);
        int edges;
        logic [8:0] exp;
        exp = 9'(ta) + 9'(tb) + 9'(tc);
        start8 = 1'b1;
        a8 = ta;
        b8 = tb;
        cin8 = tc;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        wait_done(tag, prev8, inj, 1'b0, edges);
        chk({tag, "_latency"}, 64'(edges), 64'd9);
        chk({tag, "_done"}, 64'(done8), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy8), 64'd0);
        chk({tag, "_result"}, 64'({cout8, sum8}), 64'(exp));
        prev8 = exp;
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done8), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy8), 64'd0);
        chk({tag, "_result_hold"}, 64'({cout8, sum8}), 64'(exp));
    endtask

    initial begin
        int edges;
        logic seen;
        logic [4:0] exp4;
        n_chk = 0;
        n_pass = 0;
        prev8 = 9'd0;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_result", 64'({cout8, sum8}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        op8("d5a25", 8'h5A, 8'h25, 1'b0, -1);
        op8("dff01", 8'hFF, 8'h01, 1'b0, -1);
        op8("dffff", 8'hFF, 8'hFF, 1'b1, -1);
        op8("d0000", 8'h00, 8'h00, 1'b1, -1);
        op8("busy_start", 8'h10, 8'h20, 1'b0, 3);

        // Reset in the middle of a run
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy8), 64'd0);
        chk("midrst_done", 64'(done8), 64'd0);
        chk("midrst_result", 64'({cout8, sum8}), 64'd0);
        prev8 = 9'd0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | done8 | busy8;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);

        // Back-to-back with start held high
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        wait_done("b2b1", prev8, -1, 1'b1, edges);
        chk("b2b1_latency", 64'(edges), 64'd9);
        chk("b2b1_result", 64'({cout8, sum8}), 64'h003);
        prev8 = 9'h003;
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        wait_done("b2b2", prev8, -1, 1'b1, edges);
        chk("b2b2_spacing", 64'(edges), 64'd9);
        chk("b2b2_result", 64'({cout8, sum8}), 64'h080);
        prev8 = 9'h080;
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle", 64'({busy8, done8}), 64'd0);

        for (int i = 0; i < 25; i++) begin
            op8($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), -1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                @(negedge clk);
            end
        end

        // Exhaustive WIDTH=4 sweep; each new start lands on the previous done cycle
        for (int k = 0; k < 512; k++) begin
            exp4 = 5'(k[3:0]) + 5'(k[7:4]) + 5'(k[8]);
            start4 = 1'b1;
            a4 = k[3:0];
            b4 = k[7:4];
            cin4 = k[8];
            @(posedge clk);
            edges = 1;
            @(negedge clk);
            start4 = 1'b0;
            while (!done4 && edges < 20) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            chk($sformatf("w4_done_%0d", k), 64'(done4), 64'd1);
            chk($sformatf("w4_sum_%0d", k), 64'({cout4, sum4}), 64'(exp4));
        end
        chk("w4_latency", 64'(edges), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It sequences one existing 1-bit `full_adder` instance over WIDTH clock cycles to add two WIDTH-bit operands LSB-first. The carry is held in a flop between bit slices. The block owns the operand shift registers, the bit counter, the carry flop and the result register, and presents a start/busy/done handshake to the requester. It is the area-minimal alternative to a ripple-carry adder in the Adders library.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CW, $clog2(WIDTH) (derived localparam, not overridable), bit-counter width.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an addition; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum/cout valid from this cycle.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out; held with sum.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0, shift registers=0.
- Reset has priority over every other input. An rst during RUN aborts the operation with no done pulse and clears sum/cout to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, capture a, b and cin into opA, opB and the carry flop, clear the counter, go to RUN. On start=0, stay in IDLE.
- RUN, each cycle:
  - The full_adder is driven with opA[0], opB[0] and the carry flop.
  - Its sum bit is shifted into the MSB of the result shift register (shift right).
  - Its carry output is loaded into the carry flop.
  - opA and opB shift right by one.
  - counter increments.
  - When counter==WIDTH-1, the cycle still processes the final bit, then moves to DONE. On that same edge, load sum from the completed shift value and cout from the final full_adder carry.
- DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation, go to RUN); otherwise go to IDLE.
- busy is high in RUN only. It is low in IDLE and DONE, and low on the done cycle.
- Latency: an edge that accepts start is followed by WIDTH RUN edges. done is high in the cycle after the (WIDTH+1)th edge counted from the start-accepting edge. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. It must not alter the operands, the counter or the result.
- a, b and cin may change freely after acceptance. Only the captured values are used.
- sum and cout change only on the edge entering DONE (or on rst). They remain stable for the whole of RUN, so the previous result stays readable.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- A start held high continuously yields back-to-back operations. Each captures a/b/cin on its IDLE/DONE acceptance edge.

Test Plan:
- WIDTH=8, reset 2 cycles, then start one cycle with a=0x5A, b=0x25, cin=0 -> busy high for 8 cycles; done pulses exactly 9 edges after acceptance; sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Busy-start rejection: start a=0x10, b=0x20, cin=0; during RUN cycle 3, pulse start with a=0xAA, b=0x55, change a/b, then hold them -> single done, sum=0x30, cout=0, no second operation.
- Reset mid-operation: start a=0x80, b=0x80; assert rst at RUN cycle 4 for one cycle -> next cycle busy=0, done=0, sum=0x00, cout=0, state IDLE; no done pulse follows.
- Back-to-back: keep start=1, with the first operands a=0x01, b=0x02 captured and a=0x7F, b=0x01 presented at the done cycle -> done pulses 9 cycles apart; results 0x03/cout0 then 0x80/cout0; sum holds 0x03 throughout the second RUN.
- Exhaustive check at WIDTH=4: all 512 (a, b, cin) combinations -> {cout, sum} equals a+b+cin for every one.
